// File: rtl/auth_pkg.sv
// Shared types and defaults for the rider-authentication controller.
package auth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_KEY  = 3'd1,
      ST_PWR  = 3'd2,
      ST_HOLD = 3'd3,
      ST_LOCK = 3'd4
   } auth_state_t;

   localparam logic [31:0] KEY_DEFAULT       = 32'h0000_676F;
   localparam logic [7:0]  STOP_BYTE_DEFAULT = 8'h73;

   // Key byte idx of a len-byte key; byte 0 is the most significant used byte.
   function automatic logic [7:0] key_byte(input logic [31:0] i_key,
                                           input int          i_len,
                                           input int          i_idx);
      int sh;
      sh = 8 * (i_len - 1 - i_idx);
      if (sh < 0) return 8'h00;
      return 8'(i_key >> sh);
   endfunction

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter that saturates at zero; terminal count is a decode of zero.
module auth_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_tc_c
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_cnt <= '0;
      else if (i_load)              r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
   end

   assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/auth_seq_sm.sv
// Rider-authentication controller: key match, power hold, timeout and lockout.
// Optional keep-alive watchdog in PWR when AUTH_WDOG_EN is defined.
module auth_seq_sm
   import auth_pkg::*;
#(
   parameter int unsigned KEY_LEN     = 2,
   parameter logic [31:0] KEY         = KEY_DEFAULT,
   parameter logic [7:0]  STOP_BYTE   = STOP_BYTE_DEFAULT,
   parameter int unsigned BYTE_TMO    = 50_000,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 1_000_000,
   parameter int unsigned WDOG_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rider_off,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   output logic       clr_rx_rdy,
   output logic       pwr_up,
   output logic       locked,
   output logic [2:0] auth_state
);

   localparam int unsigned BYTE_W   = $clog2(BYTE_TMO) + 1;
   localparam int unsigned LOCK_W   = $clog2(LOCK_CYCLES) + 1;
   localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);
   localparam logic [1:0]  LAST_IDX = 2'(KEY_LEN - 1);

   if (KEY_LEN < 1 || KEY_LEN > 4 || MAX_FAIL < 1 || BYTE_TMO < 1 ||
       LOCK_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_err
      $error("auth_seq_sm: illegal parameter set");
   end

   auth_state_t       r_state, w_state_nxt;
   logic [1:0]        r_key_idx, w_key_idx_nxt;
   logic [FAIL_W-1:0] r_fail_cnt, w_fail_nxt;
   logic [FAIL_W-1:0] w_fail_inc;
   logic              w_fail_lock;
   logic              w_key_hit, w_key_last;
   logic              w_byte_load, w_byte_tc;
   logic              w_lock_load, w_lock_tc;

   assign w_key_hit   = (rx_data == key_byte(KEY, int'(KEY_LEN), int'(r_key_idx)));
   assign w_key_last  = (r_key_idx == LAST_IDX);
   assign w_fail_inc  = r_fail_cnt + FAIL_W'(1);
   assign w_fail_lock = (w_fail_inc >= FAIL_W'(MAX_FAIL));

   // A byte that lands us in KEY is always an accepted key byte.
   assign w_byte_load = rx_rdy && (w_state_nxt == ST_KEY);
   assign w_lock_load = (w_state_nxt == ST_LOCK) && (r_state != ST_LOCK);

   auth_timer #(.W(BYTE_W)) u_byte_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_byte_load),
      .i_load_val (BYTE_W'(BYTE_TMO - 1)),
      .i_en       (r_state == ST_KEY),
      .o_tc_c     (w_byte_tc)
   );

   auth_timer #(.W(LOCK_W)) u_lock_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_lock_load),
      .i_load_val (LOCK_W'(LOCK_CYCLES - 1)),
      .i_en       (r_state == ST_LOCK),
      .o_tc_c     (w_lock_tc)
   );

`ifdef AUTH_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES) + 1;
   logic w_wdog_load, w_wdog_tc;

   // Restart on entry to PWR and on every byte received while powered.
   assign w_wdog_load = (w_state_nxt == ST_PWR) && ((r_state != ST_PWR) || rx_rdy);

   auth_timer #(.W(WDOG_W)) u_wdog_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_wdog_load),
      .i_load_val (WDOG_W'(WDOG_CYCLES - 1)),
      .i_en       (r_state == ST_PWR),
      .o_tc_c     (w_wdog_tc)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_key_idx  <= '0;
         r_fail_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_key_idx  <= w_key_idx_nxt;
         r_fail_cnt <= w_fail_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_key_idx_nxt = r_key_idx;
      w_fail_nxt    = r_fail_cnt;
      case (r_state)
         ST_IDLE: begin
            if (rx_rdy && w_key_hit) begin
               if (w_key_last) begin
                  w_state_nxt   = ST_PWR;
                  w_key_idx_nxt = '0;
                  w_fail_nxt    = '0;
               end else begin
                  w_state_nxt   = ST_KEY;
                  w_key_idx_nxt = 2'd1;
               end
            end
         end
         ST_KEY: begin
            if (rx_rdy && w_key_hit) begin
               if (w_key_last) begin
                  w_state_nxt   = ST_PWR;
                  w_key_idx_nxt = '0;
                  w_fail_nxt    = '0;
               end else begin
                  w_key_idx_nxt = r_key_idx + 2'd1;
               end
            end else if (rx_rdy || w_byte_tc) begin
               w_key_idx_nxt = '0;
               w_fail_nxt    = w_fail_inc;
               w_state_nxt   = w_fail_lock ? ST_LOCK : ST_IDLE;
            end
         end
         ST_PWR: begin
            if (rx_rdy && rx_data == STOP_BYTE) begin
               w_state_nxt = rider_off ? ST_IDLE : ST_HOLD;
`ifdef AUTH_WDOG_EN
            end else if (!rx_rdy && w_wdog_tc) begin
               w_state_nxt = rider_off ? ST_IDLE : ST_HOLD;
`endif
            end
         end
         ST_HOLD: begin
            if (rider_off) begin
               w_state_nxt   = ST_IDLE;
               w_key_idx_nxt = '0;
            end else if (rx_rdy) begin
               if (!w_key_hit) begin
                  w_key_idx_nxt = '0;
               end else if (w_key_last) begin
                  w_state_nxt   = ST_PWR;
                  w_key_idx_nxt = '0;
               end else begin
                  w_key_idx_nxt = r_key_idx + 2'd1;
               end
            end
         end
         ST_LOCK: begin
            if (w_lock_tc) begin
               w_state_nxt = ST_IDLE;
               w_fail_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_key_idx_nxt = '0;
         end
      endcase
   end

   assign clr_rx_rdy = rx_rdy;
   assign pwr_up     = (r_state == ST_PWR) || (r_state == ST_HOLD);
   assign locked     = (r_state == ST_LOCK);
   assign auth_state = r_state;

endmodule

// File: tb/tb_auth_seq_sm.sv
// Scoreboard bench for auth_seq_sm: stimulus queues expected post-states, monitor compares.
module tb_auth_seq_sm;
   import auth_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rider_off = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdy = 1'b0;
   logic       clr_rx_rdy, pwr_up, locked;
   logic [2:0] auth_state;

   auth_seq_sm #(
      .KEY_LEN     (2),
      .KEY         (32'h0000_676F),
      .STOP_BYTE   (8'h73),
      .BYTE_TMO    (100),
      .MAX_FAIL    (3),
      .LOCK_CYCLES (500),
      .WDOG_CYCLES (1000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rider_off  (rider_off),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .pwr_up     (pwr_up),
      .locked     (locked),
      .auth_state (auth_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      auth_state_t st;
      logic        pwr;
      logic        lk;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   req_cnt = 0;
   int   ack_cnt = 0;
   bit   end_req = 1'b0;

   function automatic exp_t mk(input string n, input auth_state_t s, input logic p, input logic l);
      exp_t e;
      e.name = n;
      e.st   = s;
      e.pwr  = p;
      e.lk   = l;
      return e;
   endfunction

   // One byte: rdy for a single cycle, expected state is the one after that cycle.
   task automatic send(input logic [7:0] b, input string n, input auth_state_t s,
                       input logic p, input logic l);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_rdy  = 1'b1;
      exp_q.push_back(mk(n, s, p, l));
      @(posedge clk);
      #1;
      rx_rdy = 1'b0;
   endtask

   task automatic check_now(input string n, input auth_state_t s, input logic p, input logic l);
      exp_q.push_back(mk(n, s, p, l));
      req_cnt++;
   endtask

   initial begin : monitor
      bit   pend;
      exp_t e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         n_vec++;
         if (clr_rx_rdy !== rx_rdy) begin
            n_fail++;
            $display("FAIL clr_rx_rdy: got %b want %b at %0t", clr_rx_rdy, rx_rdy, $time);
         end
         for (int k = 0; k < 2; k++) begin
            if ((k == 0 && pend) || (k == 1 && req_cnt != ack_cnt)) begin
               if (k == 1) ack_cnt++;
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  if (auth_state !== 3'(e.st) || pwr_up !== e.pwr || locked !== e.lk) begin
                     n_fail++;
                     $display("FAIL %s: got state=%0d pwr_up=%b locked=%b want state=%0d pwr_up=%b locked=%b",
                              e.name, auth_state, pwr_up, locked, 3'(e.st), e.pwr, e.lk);
                  end
               end
            end
         end
         pend = rx_rdy;
         if (end_req) begin
            n_vec++;
            if (exp_q.size() != 0 || req_cnt != ack_cnt) begin
               n_fail++;
               $display("FAIL drain: got %0d pending want 0", exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
            $finish;
         end
      end
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check_now("reset", ST_IDLE, 1'b0, 1'b0);

      // Basic unlock, bytes 20 cycles apart
      send(8'h67, "key0", ST_KEY, 1'b0, 1'b0);
      repeat (18) @(posedge clk);
      send(8'h6F, "key1", ST_PWR, 1'b1, 1'b0);

      // HOLD: stop with rider on, re-key, rider_off exits
      send(8'h73, "stop_hold",  ST_HOLD, 1'b1, 1'b0);
      send(8'h67, "hold_k0",    ST_HOLD, 1'b1, 1'b0);
      send(8'h00, "hold_bad",   ST_HOLD, 1'b1, 1'b0);
      send(8'h6F, "hold_nokey", ST_HOLD, 1'b1, 1'b0);
      send(8'h67, "hold_k0b",   ST_HOLD, 1'b1, 1'b0);
      send(8'h6F, "hold_rekey", ST_PWR,  1'b1, 1'b0);
      send(8'h73, "stop_hold2", ST_HOLD, 1'b1, 1'b0);
      rider_off = 1'b1;
      check_now("hold_roff_pre", ST_HOLD, 1'b1, 1'b0);
      @(posedge clk);
      #1 check_now("hold_roff", ST_IDLE, 1'b0, 1'b0);
      rider_off = 1'b0;

      // Byte timeout boundary
      send(8'h67, "tmo_k0", ST_KEY, 1'b0, 1'b0);
      repeat (98) @(posedge clk);
      #1 check_now("tmo_edge", ST_KEY, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 check_now("tmo", ST_IDLE, 1'b0, 1'b0);

      // Byte arrives in the very cycle the timer expires
      send(8'h67, "race_k0", ST_KEY, 1'b0, 1'b0);
      repeat (98) @(posedge clk);
      send(8'h6F, "tmo_race", ST_PWR, 1'b1, 1'b0);
      rider_off = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_now("roff_pwr", ST_PWR, 1'b1, 1'b0);
      send(8'h73, "stop_off", ST_IDLE, 1'b0, 1'b0);
      rider_off = 1'b0;

      // Three failures lock; second failure repeats KEY[0]
      send(8'h67, "f1_k0",    ST_KEY,  1'b0, 1'b0);
      send(8'h00, "fail1",    ST_IDLE, 1'b0, 1'b0);
      send(8'h67, "f2_k0",    ST_KEY,  1'b0, 1'b0);
      send(8'h67, "fail2_k0", ST_IDLE, 1'b0, 1'b0);
      send(8'h67, "f3_k0",    ST_KEY,  1'b0, 1'b0);
      send(8'h00, "fail3",    ST_LOCK, 1'b0, 1'b1);
      send(8'h67, "lock_k0",  ST_LOCK, 1'b0, 1'b1);
      send(8'h6F, "lock_k1",  ST_LOCK, 1'b0, 1'b1);
      repeat (494) @(posedge clk);
      #1 check_now("lock_edge", ST_LOCK, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1 check_now("unlock", ST_IDLE, 1'b0, 1'b0);
      send(8'h67, "pl_k0",     ST_KEY, 1'b0, 1'b0);
      send(8'h6F, "post_lock", ST_PWR, 1'b1, 1'b0);

      // Keep-alive window with rider off
      rider_off = 1'b1;
      repeat (998) @(posedge clk);
      #1 check_now("wdog_edge", ST_PWR, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
`ifdef AUTH_WDOG_EN
      #1 check_now("wdog", ST_IDLE, 1'b0, 1'b0);
`else
      #1 check_now("no_wdog", ST_PWR, 1'b1, 1'b0);
`endif
      send(8'h73, "wd_stop", ST_IDLE, 1'b0, 1'b0);

      // rider_off beats the final key byte in HOLD
      rider_off = 1'b0;
      send(8'h67, "h_k0",  ST_KEY,  1'b0, 1'b0);
      send(8'h6F, "h_k1",  ST_PWR,  1'b1, 1'b0);
      send(8'h73, "h_stp", ST_HOLD, 1'b1, 1'b0);
      send(8'h67, "h_k0b", ST_HOLD, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rx_data   = 8'h6F;
      rx_rdy    = 1'b1;
      rider_off = 1'b1;
      exp_q.push_back(mk("hold_race", ST_IDLE, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rx_rdy    = 1'b0;
      rider_off = 1'b0;

      // Asynchronous reset from PWR
      send(8'h67, "r_k0", ST_KEY, 1'b0, 1'b0);
      send(8'h6F, "r_k1", ST_PWR, 1'b1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      check_now("async_rst", ST_IDLE, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check_now("rst_rel", ST_IDLE, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      end_req = 1'b1;
   end

endmodule

// File: doc/auth_seq_sm.md
Name: auth_seq_sm

Overview:
Parametrised rider-authentication controller for the scooter power path.
- Consumes bytes from an external UART receiver and matches a multi-byte unlock key.
- Grants `pwr_up`, and on a stop byte holds power until the rider steps off.
- Adds inter-byte timeout, failed-attempt lockout and an optional keep-alive watchdog.
- Sits between `UART_rx` and the power/balance controller.

Parameters:
- KEY_LEN, 2, number of key bytes (1..4).
- KEY, 32'h0000_676F, key bytes; first expected byte is `KEY[8*KEY_LEN-1 -: 8]`; unused upper bytes ignored.
- STOP_BYTE, 8'h73, byte requesting power-down.
- BYTE_TMO, 50_000, max clk cycles between key bytes while collecting.
- MAX_FAIL, 3, consecutive failed attempts before lockout (>=1).
- LOCK_CYCLES, 1_000_000, lockout duration in clk cycles.
- WDOG_CYCLES, 5_000_000, keep-alive window (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rider_off  in  1  high when no rider on platform
- rx_data  in  8  byte from UART receiver
- rx_rdy  in  1  `rx_data` valid, held until cleared
- clr_rx_rdy  out  1  combinational; consumes current byte
- pwr_up  out  1  registered-state decode; power grant
- locked  out  1  high while in LOCK
- auth_state  out  3  current state encoding, for debug/visibility

Behaviour:
- Reset: state=IDLE, key_idx=0, fail_cnt=0, all timers cleared.
  - Outputs at reset: pwr_up=0, locked=0, clr_rx_rdy=0, auth_state=IDLE.
- Byte consumption:
  - `clr_rx_rdy`=1 in every cycle `rx_rdy`=1, in all states including LOCK.
  - Each byte is processed exactly once, in the cycle `rx_rdy` is seen.
- Output decode:
  - pwr_up = (state==PWR || state==HOLD).
  - locked = (state==LOCK).
  - Both are Moore outputs from the state register, so pwr_up rises 1 cycle after the final key byte's `rx_rdy` cycle.
- States: IDLE, KEY, PWR, HOLD, LOCK.
- IDLE:
  - byte==KEY[0] → key_idx=1 and go to KEY, or straight to PWR if KEY_LEN==1.
  - Any other byte → discarded; no fail counted.
- KEY:
  - byte==KEY[key_idx] → key_idx++ and the byte timer restarts.
  - On the last key byte → PWR, with fail_cnt=0 and key_idx=0.
  - Wrong byte, or byte timer reaching BYTE_TMO with no byte → fail_cnt++, key_idx=0, go to IDLE.
  - If fail_cnt reaches MAX_FAIL → LOCK instead of IDLE.
  - A wrong byte that equals KEY[0] does not restart the sequence.
- PWR:
  - STOP_BYTE with rider_off=1 → IDLE.
  - STOP_BYTE with rider_off=0 → HOLD.
  - rider_off alone does not drop power.
  - Other bytes are discarded.
- HOLD:
  - rider_off=1 → IDLE; this has priority over any byte in the same cycle.
  - Full key sequence matched → PWR.
  - Mismatch → key_idx=0; no fail counted.
  - No byte timeout in HOLD.
- LOCK:
  - All bytes are discarded.
  - After LOCK_CYCLES cycles → IDLE with fail_cnt=0.
- Simultaneous events: `rx_rdy` and byte-timeout expiry in the same cycle → the byte wins and the timer restarts.
- Timers: width is $clog2 of the respective parameter + 1; no wrap, they saturate at the terminal count.
- Reset mid-operation returns to IDLE immediately; pwr_up drops asynchronously with state.

Optional Feature:
- Macro AUTH_WDOG_EN.
- Defined:
  - In PWR, any received byte restarts the watchdog.
  - WDOG_CYCLES with no byte acts exactly as STOP_BYTE: HOLD if rider on, IDLE if rider off.
- Undefined: no watchdog logic; WDOG_CYCLES is unused; PWR persists indefinitely.

Decomposition:
- Package `auth_pkg` contains:
  - `auth_state_t` enum (3-bit): IDLE, KEY, PWR, HOLD, LOCK.
  - Default constants for KEY and STOP_BYTE.
- Sub-module `auth_timer` (load/enable/terminal-count down-counter, parametrised width).
  - Instantiated for the byte timeout, the lockout, and the watchdog (watchdog only under AUTH_WDOG_EN).

Test Plan:
Bench config: KEY=16'h676F, KEY_LEN=2, BYTE_TMO=100, MAX_FAIL=3, LOCK_CYCLES=500, WDOG_CYCLES=1000.
- Send 0x67, then 0x6F (20 cycles apart) → clr_rx_rdy pulses on each byte; pwr_up=1 one cycle after the 0x6F rdy cycle.
- In PWR with rider_off=0, send 0x73 → HOLD, pwr_up stays 1. Then raise rider_off → IDLE, pwr_up=0 next cycle.
- Send 0x67, 0x00 three times → locked=1 after the third; a correct key during LOCK is ignored; locked=0 after 500 cycles; correct key then powers up.
- Send 0x67, wait 100 cycles → back to IDLE, fail_cnt=1. Then 0x67, 0x6F → PWR, fail_cnt=0.
- In HOLD, rider_off rises in the same cycle as the final key byte → IDLE, pwr_up=0.
- With AUTH_WDOG_EN, in PWR with rider_off=1 and no bytes for 1000 cycles → IDLE. Without the macro → pwr_up stays 1.
